// File: rtl/cpu_pc_seq_pkg.sv
// Shared types and constants for the multi-cycle PC sequencer.
package cpu_pc_pkg;

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} pc_state_e;

  localparam int   CAUSE_MISALIGN = 0;
  localparam logic CAUSE_IRQ_FLAG = 1'b1;

  // Index width that stays legal for a single interrupt line.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_pc_seq_if.sv
// Decode/ALU/interrupt side bus of the PC sequencer; master drives controls, slave is the sequencer.
interface cpu_pc_seq_if #(
  parameter int XLEN   = 32,
  parameter int N_IRQ  = 4,
  parameter int STAGES = 6
);
  localparam int CW = $clog2(N_IRQ) + 1;
  localparam int SW = $clog2(STAGES);

  logic              stall;
  logic              branch, zero, jal, jalr, mret;
  logic [XLEN-1:0]   offset;
  logic [XLEN-1:0]   result_from_alu;
  logic [N_IRQ-1:0]  irq, irq_mask;
  logic              ie_set, ie_clr;

  logic [XLEN-1:0]   pc, epc;
  logic [CW-1:0]     cause;
  logic              ie;
  logic              fetch_strobe;
  logic [N_IRQ-1:0]  int_ack;
  logic [SW-1:0]     stage;

  modport master (
    output stall, branch, zero, jal, jalr, mret, offset, result_from_alu,
           irq, irq_mask, ie_set, ie_clr,
    input  pc, epc, cause, ie, fetch_strobe, int_ack, stage
  );

  modport slave (
    input  stall, branch, zero, jal, jalr, mret, offset, result_from_alu,
           irq, irq_mask, ie_set, ie_clr,
    output pc, epc, cause, ie, fetch_strobe, int_ack, stage
  );
endinterface

// File: rtl/cpu_pc_seq_irq_prio.sv
// Lowest-index-wins priority encoder over the pending interrupt vector.
module cpu_irq_prio
  import cpu_pc_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] id,
  output logic [N-1:0]  onehot
);
  assign valid = |req;

  // Scan high to low so the last hit, the lowest index, wins.
  always_comb begin
    id     = '0;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        id        = IW'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cpu_pc_seq.sv
// Multi-cycle program-counter sequencer: stage counter, next-pc mux, interrupt/misalign trap entry, mret.
module cpu_pc_seq
  import cpu_pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              STAGES    = 6,
  parameter int              UPD_STAGE = 3,
  parameter int              N_IRQ     = 4,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h100,
  parameter bit              VECTORED  = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  cpu_pc_seq_if.slave   bus
);
  localparam int SW = $clog2(STAGES);
  localparam int CW = $clog2(N_IRQ) + 1;
  localparam int IW = clog2_min1(N_IRQ);
  localparam logic [SW-1:0] UPD_S  = SW'(UPD_STAGE);
  localparam logic [SW-1:0] LAST_S = SW'(STAGES - 1);

  pc_state_e        state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [XLEN-1:0]  pc_q, pc_d, epc_q, epc_d;
  logic [CW-1:0]    cause_q, cause_d;
  logic             ie_q, ie_d;
  logic [N_IRQ-1:0] ack_q, ack_d;

  logic [N_IRQ-1:0] pend, irq_onehot;
  logic             irq_vld;
  logic [IW-1:0]    irq_id;
  logic [XLEN-1:0]  tgt, vec_off;
  logic [CW-1:0]    cause_irq;

  assign pend = bus.irq & bus.irq_mask & {N_IRQ{ie_q}};

  cpu_irq_prio #(.N(N_IRQ), .IW(IW)) u_prio (
    .req    (pend),
    .valid  (irq_vld),
    .id     (irq_id),
    .onehot (irq_onehot)
  );

  assign vec_off   = VECTORED ? (XLEN'(irq_id) << 2) : '0;
  assign cause_irq = (CW'(CAUSE_IRQ_FLAG) << (CW - 1)) | CW'(irq_id);

  always_comb begin
    tgt = pc_q + XLEN'(4);
    if (bus.branch)    tgt = bus.zero ? pc_q + bus.offset : pc_q + XLEN'(4);
    else if (bus.jal)  tgt = pc_q + bus.offset;
    else if (bus.jalr) tgt = bus.result_from_alu & ~XLEN'(1);
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    ie_d    = ie_q;
    ack_d   = '0;
    // ie pulses are frozen by stall except in TRAP, where stall has no effect.
    if (state_q == TRAP || !bus.stall) begin
      if (bus.ie_clr)      ie_d = 1'b0;
      else if (bus.ie_set) ie_d = 1'b1;
    end
    case (state_q)
      RUN: if (!bus.stall) begin
        stage_d = (stage_q == LAST_S) ? '0 : stage_q + SW'(1);
        if (stage_q == UPD_S) begin
          if (bus.mret) begin
            pc_d = epc_q;
            if (!bus.ie_clr) ie_d = 1'b1;
          end else if (tgt[1:0] != 2'b00) begin
            epc_d   = pc_q;
            cause_d = CW'(CAUSE_MISALIGN);
            ie_d    = 1'b0;
            pc_d    = TRAP_VEC;
          end else begin
            pc_d = tgt;
          end
        end
        if (stage_q == LAST_S && irq_vld) begin
          epc_d   = pc_q;
          cause_d = cause_irq;
          ie_d    = 1'b0;
          pc_d    = TRAP_VEC + vec_off;
          state_d = TRAP;
          ack_d   = irq_onehot;
        end
      end
      TRAP: begin
        state_d = RUN;
        stage_d = '0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      stage_q <= '0;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      cause_q <= '0;
      ie_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      ie_q    <= ie_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.epc          = epc_q;
  assign bus.cause        = cause_q;
  assign bus.ie           = ie_q;
  assign bus.int_ack      = ack_q;
  assign bus.stage        = stage_q;
  assign bus.fetch_strobe = (state_q == RUN) && (stage_q == '0) && !bus.stall;
endmodule
